// File: rtl/red_lut_pipe_pkg.sv
// red_pkg: shared defaults, FSM state type and the fold weight for the
// folding reducer (red_lut_pipe) and its interface.
package red_pkg;
  localparam int DATA_SIZE_DEF = 40;
  localparam int M_BITS_DEF    = 3;
  localparam int TAG_W_DEF     = 8;

  localparam logic [DATA_SIZE_DEF-1:0] P_DEFAULT = 40'h85BFC65FEF;

  // Weight of one fold unit, 2^(DATA_SIZE-1), at the default width.
  localparam logic [DATA_SIZE_DEF-1:0] HALF = {1'b1, {(DATA_SIZE_DEF-1){1'b0}}};

  typedef enum logic {
    REBUILD = 1'b0,
    RUN     = 1'b1
  } state_t;
endpackage

// File: rtl/red_lut_pipe_if.sv
// red_lut_pipe_if: operand stream, result stream and modulus-load channel
// of the folding reducer, plus its busy flag.
//   master : drives in_valid/in_data/in_tag, out_ready, cfg_valid/cfg_p
//   slave  : drives in_ready, out_valid/out_data/out_tag, cfg_ready,
//            cfg_err, busy
interface red_lut_pipe_if #(
  parameter int DATA_SIZE = red_pkg::DATA_SIZE_DEF,
  parameter int M_BITS    = red_pkg::M_BITS_DEF,
  parameter int TAG_W     = red_pkg::TAG_W_DEF
);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_SIZE+M_BITS-2:0] in_data;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_SIZE-1:0]        out_data;
  logic [TAG_W-1:0]            out_tag;
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [DATA_SIZE-1:0]        cfg_p;
  logic                        cfg_err;
  logic                        busy;

  modport master (
    output in_valid, in_data, in_tag, out_ready, cfg_valid, cfg_p,
    input  in_ready, out_valid, out_data, out_tag, cfg_ready, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready, cfg_valid, cfg_p,
    output in_ready, out_valid, out_data, out_tag, cfg_ready, cfg_err, busy
  );
endinterface

// File: rtl/red_lut_pipe_ram.sv
// red_lut_ram: 2^M_BITS x DATA_SIZE correction table.
//   clk          : clock
//   we/waddr/wdata : synchronous write port (table rebuild)
//   raddr/rdata  : asynchronous read port (pipeline stage 1)
module red_lut_ram #(
  parameter int DATA_SIZE = 40,
  parameter int M_BITS    = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [M_BITS-1:0]    waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [M_BITS-1:0]    raddr,
  output logic [DATA_SIZE-1:0] rdata
);
  logic [DATA_SIZE-1:0] mem [2**M_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/red_lut_pipe.sv
// red_lut_pipe: pipelined modular folding reducer. An operand
// {M, low} is reduced as (M*2^(DATA_SIZE-1) + low) mod p using a table of
// k*2^(DATA_SIZE-1) mod p rebuilt in hardware whenever p is (re)loaded.
//   clk, rst : clock, synchronous active-high reset
//   bus      : red_lut_pipe_if.slave (operand/result streams, cfg, busy)
//
// state   | meaning
// REBUILD | filling table entries 1..2^M_BITS-1 from p_reg, no operands
// RUN     | 2-stage reduce pipeline live, modulus loads accepted when idle
module red_lut_pipe #(
  parameter int                   DATA_SIZE = red_pkg::DATA_SIZE_DEF,
  parameter int                   M_BITS    = red_pkg::M_BITS_DEF,
  parameter logic [DATA_SIZE-1:0] P_DEFAULT = red_pkg::P_DEFAULT,
  parameter int                   TAG_W     = red_pkg::TAG_W_DEF
) (
  input logic           clk,
  input logic           rst,
  red_lut_pipe_if.slave bus
);
  import red_pkg::*;

  localparam logic [DATA_SIZE:0] HALF_W = {2'b01, {(DATA_SIZE-1){1'b0}}};

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] p_reg, acc, acc_nxt;
  logic [DATA_SIZE:0]   p_ext, t;
  logic [M_BITS-1:0]    k;
  logic                 run, load_p, cfg_fire, cfg_ok, cfg_ready;
  logic                 s2_adv, s1_open, in_ready, in_fire;
  logic                 s1_valid, out_valid_q, cfg_err_q;
  logic [DATA_SIZE:0]   s1_sum, sum;
  logic [TAG_W-1:0]     s1_tag, out_tag_q;
  logic [DATA_SIZE-1:0] out_data_q, red_out, tbl_rdata, tbl_wdata;
  logic [M_BITS-1:0]    tbl_waddr, op_m;
  logic [DATA_SIZE-2:0] op_low;
  logic                 tbl_we;

  assign run   = (state == RUN);
  assign p_ext = {1'b0, p_reg};

  // Next table entry: previous entry plus one fold unit, reduced once.
  assign t       = {1'b0, acc} + HALF_W;
  assign acc_nxt = (t >= p_ext) ? DATA_SIZE'(t - p_ext) : t[DATA_SIZE-1:0];

  assign s2_adv    = !out_valid_q || bus.out_ready;
  assign s1_open   = !s1_valid || s2_adv;
  assign cfg_ready = run && !s1_valid && !out_valid_q;
  assign cfg_fire  = bus.cfg_valid && cfg_ready;
  assign cfg_ok    = ({1'b0, bus.cfg_p} > HALF_W) && bus.cfg_p[0];
  assign load_p    = cfg_fire && cfg_ok;
  // A modulus load wins over an operand offered in the same cycle.
  assign in_ready  = run && !cfg_fire && s1_open;
  assign in_fire   = bus.in_valid && in_ready;

  assign op_m   = bus.in_data[DATA_SIZE+M_BITS-2 -: M_BITS];
  assign op_low = bus.in_data[DATA_SIZE-2:0];
  assign sum    = {2'b00, op_low} + {1'b0, tbl_rdata};
  // sum < 2p, so a single conditional subtract fully reduces it.
  assign red_out = (s1_sum >= p_ext) ? DATA_SIZE'(s1_sum - p_ext)
                                     : s1_sum[DATA_SIZE-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      REBUILD: if (k == '1) state_nxt = RUN;
      RUN:     if (load_p)  state_nxt = REBUILD;
      default: state_nxt = REBUILD;
    endcase
  end

  // Entry 0 is always zero; it is (re)written while the write port is
  // otherwise idle, i.e. in the reset or load cycle.
  always_comb begin
    tbl_we    = rst || load_p || !run;
    tbl_waddr = k;
    tbl_wdata = acc_nxt;
    if (rst || load_p) begin
      tbl_waddr = '0;
      tbl_wdata = '0;
    end
  end

  red_lut_ram #(.DATA_SIZE(DATA_SIZE), .M_BITS(M_BITS)) u_ram (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (op_m),
    .rdata (tbl_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REBUILD;
      p_reg       <= P_DEFAULT;
      acc         <= '0;
      k           <= M_BITS'(1);
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_tag      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_err_q <= cfg_fire && !cfg_ok;
      if (load_p) begin
        p_reg <= bus.cfg_p;
        acc   <= '0;
        k     <= M_BITS'(1);
      end else if (!run) begin
        acc <= acc_nxt;
        k   <= k + M_BITS'(1);
      end
      if (s1_open) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_sum <= sum;
          s1_tag <= bus.in_tag;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_data_q <= red_out;
          out_tag_q  <= s1_tag;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = !run;
endmodule

// File: tb/tb_red_lut_pipe.sv
module tb_red_lut_pipe;
  import red_pkg::*;

  localparam int DW = 40;
  localparam int MB = 3;
  localparam int TW = 8;
  localparam logic [39:0] P_ALT = 40'h8000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  red_lut_pipe_if #(.DATA_SIZE(DW), .M_BITS(MB), .TAG_W(TW)) bus ();

  red_lut_pipe #(.DATA_SIZE(DW), .M_BITS(MB), .P_DEFAULT(P_DEFAULT), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] cur_p;
  logic [39:0] exp_d[$];
  logic [7:0]  exp_t[$];
  int          exp_c[$];
  logic [39:0] got_d[$];
  logic [7:0]  got_t[$];
  int          got_lat[$];
  int          got_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = M*2^39 + low, reduced mod p.
  function automatic logic [39:0] ref_red(input logic [2:0] m, input logic [38:0] lo,
                                          input logic [39:0] p);
    logic [63:0] v;
    v = (64'(m) << 39) + 64'(lo);
    return 40'(v % 64'(p));
  endfunction

  // Scoreboard: sampled 1 ns before each rising edge.
  initial begin
    logic [39:0] ed;
    logic [7:0]  et;
    int          ec;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        exp_d.delete(); exp_t.delete(); exp_c.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_d.size() == 0) begin
            chk("spurious_out", 64'(exp_d.size()), 64'd1);
          end else begin
            ed = exp_d.pop_front();
            et = exp_t.pop_front();
            ec = exp_c.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(ed));
            chk("out_tag", 64'(bus.out_tag), 64'(et));
            got_d.push_back(bus.out_data);
            got_t.push_back(bus.out_tag);
            got_lat.push_back(cyc - ec);
            got_cyc.push_back(cyc);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_d.push_back(ref_red(bus.in_data[41:39], bus.in_data[38:0], cur_p));
          exp_t.push_back(bus.in_tag);
          exp_c.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_got();
    got_d.delete(); got_t.delete(); got_lat.delete(); got_cyc.delete();
  endtask

  task automatic send(input logic [2:0] m, input logic [38:0] lo, input logic [7:0] tg);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {m, lo};
    bus.in_tag   = tg;
    #4;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk); #4; t++;
    end
    if (!bus.in_ready) chk("send_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_d.size() != 0 || bus.out_valid) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("drain_empty", 64'(exp_d.size()), 64'd0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic do_cfg(input logic [39:0] p);
    int t = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_p     = p;
    #4;
    while (!bus.cfg_ready && t < 100) begin
      @(negedge clk); #4; t++;
    end
    chk("cfg_ready", 64'(bus.cfg_ready), 64'd1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int n, idx, t;
    bit fired;
    logic [39:0] tbl_exp [8];
    logic [2:0]  bp_m  [4];
    logic [38:0] bp_lo [4];
    logic [7:0]  bp_tg [4];
    logic [39:0] p_rand;

    tbl_exp = '{40'h0, 40'h8000000000, 40'h7a4039a011, 40'h7480734022,
                40'h6ec0ace033, 40'h6900e68044, 40'h6341202055, 40'h5d8159c066};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1; bus.cfg_valid = 1'b0; bus.cfg_p = '0;
    cur_p = P_DEFAULT;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd1);

    rst = 1'b0;
    count_busy(n);
    chk("rebuild_cycles", 64'(n), 64'd7);
    chk("in_ready_run", 64'(bus.in_ready), 64'd1);

    // Table contents via M=k, low=0.
    clear_got();
    for (int m = 0; m < 8; m++) send(3'(m), '0, 8'(m));
    drain();
    chk("table_count", 64'(got_d.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) chk("table_entry", 64'(got_d[i]), 64'(tbl_exp[i]));

    // Back-to-back stream.
    clear_got();
    send(3'd3, 39'd0, 8'h11);
    send(3'd7, 39'h7FFFFFFFFF, 8'h22);
    drain();
    chk("stream_count", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      chk("stream_d0", 64'(got_d[0]), 64'h7480734022);
      chk("stream_t0", 64'(got_t[0]), 64'h11);
      chk("stream_d1", 64'(got_d[1]), 64'h57C1936076);
      chk("stream_t1", 64'(got_t[1]), 64'h22);
      chk("latency0", 64'(got_lat[0]), 64'd2);
      chk("latency1", 64'(got_lat[1]), 64'd2);
      chk("back_to_back", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
    end

    // Backpressure: only two operands fit while the output is stalled.
    clear_got();
    for (int i = 0; i < 4; i++) begin
      bp_m[i] = 3'($urandom); bp_lo[i] = 39'({$urandom, $urandom}); bp_tg[i] = 8'(i + 8'hA0);
    end
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_valid = 1'b1; bus.in_data = {bp_m[0], bp_lo[0]}; bus.in_tag = bp_tg[0];
    for (int c = 0; c < 6; c++) begin
      #4;
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
      if (idx < 4) begin bus.in_data = {bp_m[idx], bp_lo[idx]}; bus.in_tag = bp_tg[idx]; end
      else bus.in_valid = 1'b0;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_data", 64'(bus.out_data), 64'(ref_red(bp_m[0], bp_lo[0], cur_p)));
    bus.out_ready = 1'b1;
    t = 0;
    while (idx < 4 && t < 50) begin
      #4;
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
      if (idx < 4) begin bus.in_data = {bp_m[idx], bp_lo[idx]}; bus.in_tag = bp_tg[idx]; end
      else bus.in_valid = 1'b0;
      t++;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_count", 64'(got_t.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_t.size(); i++) chk("bp_tag_order", 64'(got_t[i]), 64'(bp_tg[i]));

    // Valid modulus load.
    do_cfg(P_ALT);
    cur_p = P_ALT;
    chk("cfg_busy", 64'(bus.busy), 64'd1);
    count_busy(n);
    chk("cfg_rebuild_cycles", 64'(n), 64'd7);
    clear_got();
    send(3'd2, 39'd0, 8'h5A);
    send(3'd2, 39'd1, 8'h5B);
    drain();
    chk("alt_count", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      chk("alt_table2", 64'(got_d[0]), 64'h7FFFFFFFFF);
      chk("alt_result", 64'(got_d[1]), 64'h8000000000);
    end

    do_cfg(P_DEFAULT);
    cur_p = P_DEFAULT;
    count_busy(n);
    chk("restore_rebuild", 64'(n), 64'd7);

    // Rejected loads: exactly HALF, and an even value.
    do_cfg(40'h8000000000);
    chk("err_half_pulse", 64'(bus.cfg_err), 64'd1);
    chk("err_half_nobusy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("err_half_clear", 64'(bus.cfg_err), 64'd0);
    do_cfg(40'h85BFC65FF0);
    chk("err_even_pulse", 64'(bus.cfg_err), 64'd1);
    chk("err_even_nobusy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("err_even_clear", 64'(bus.cfg_err), 64'd0);
    clear_got();
    send(3'd3, 39'd0, 8'h33);
    drain();
    chk("err_unchanged", 64'(got_d.size() > 0 ? got_d[0] : 40'h0), 64'h7480734022);

    // Random modulus and random stream with random backpressure.
    p_rand = {1'b1, 39'({$urandom, $urandom})} | 40'h1;
    do_cfg(p_rand);
    cur_p = p_rand;
    count_busy(n);
    fired = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || fired) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.in_data  = 42'({$urandom, $urandom});
        bus.in_tag   = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #4;
      fired = bus.in_valid && bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a rebuild.
    do_cfg(P_ALT);
    cur_p = P_ALT;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rebuild_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    cur_p = P_DEFAULT;
    count_busy(n);
    chk("rst_rebuild_restart", 64'(n), 64'd7);
    clear_got();
    send(3'd7, 39'h7FFFFFFFFF, 8'h44);
    drain();
    chk("rst_default_p", 64'(got_d.size() > 0 ? got_d[0] : 40'h0), 64'h57C1936076);

    // Reset with both pipeline stages full.
    bus.out_ready = 1'b0;
    send(3'd1, 39'd5, 8'h01);
    send(3'd2, 39'd6, 8'h02);
    chk("full_before_rst", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_full_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    clear_got();
    count_busy(n);
    chk("rst_full_restart", 64'(n), 64'd7);
    repeat (4) @(negedge clk);
    chk("no_stale_out", 64'(got_d.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
